spi_word_slave: RTL and testbench

Oversampling SPI slave that terminates the controller's 48-bit command/data frames inside the FPGA. It sits directly downstream of the SPI master. It synchronises `_cs`/`sclk`/`mosi` into the system clock domain and splits each frame into a 16-bit header and a 32-bit write word. During the data phase it returns a 32-bit response word on MISO. Header and data are presented to the register/command decoder as single-cycle valid pulses.

---
 rtl/spi_word_slave_pkg.sv | 15 +
 rtl/spi_word_slave_sync_edge.sv | 26 ++
 rtl/spi_word_slave.sv | 161 ++++++++++++++++
 tb/tb_spi_word_slave.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_word_slave_pkg.sv
// Shared types and default frame geometry for the SPI word slave.
package spi_word_slave_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int HDR_W_DEF      = 16;
   localparam int DATA_W_DEF     = 32;
   localparam int FRAME_BITS_DEF = HDR_W_DEF + DATA_W_DEF;

endpackage

// File: rtl/spi_word_slave_sync_edge.sv
// Input synchroniser plus one history flop for edge detection (module spi_sync_edge).
module spi_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic d,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // No reset: the chain simply tracks the pin, and prev_q follows level so
   // no phantom edge appears when the controller leaves reset.
   always_ff @(posedge clk) begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_word_slave.sv
// Oversampling mode-0 SPI slave splitting 48-bit frames into header and data words.
// Optional back-to-back frames under one chip select: define SPI_WORD_SLAVE_MULTIFRAME_EN.
//
// state | meaning
// IDLE  | chip select high, waiting for its falling edge
// HDR   | shifting header bits in on sclk rises
// DATA  | shifting data bits in, response bits out on sclk falls
// DONE  | frame finished or reset mid-frame; wait for chip select high
module spi_word_slave
   import spi_word_slave_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int HDR_W       = HDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              _cs_i,
   input  logic              sclk_i,
   input  logic              mosi_i,
   output logic              miso_o,
   output logic              miso_oe,
   output logic [HDR_W-1:0]  hdr_o,
   output logic              hdr_valid,
   input  logic [DATA_W-1:0] rsp_i,
   output logic [DATA_W-1:0] data_o,
   output logic              data_valid,
   output logic              frame_abort,
   output logic              busy
);

`ifdef SPI_WORD_SLAVE_MULTIFRAME_EN
   localparam bit MULTIFRAME = 1'b1;
`else
   localparam bit MULTIFRAME = 1'b0;
`endif

   localparam logic [5:0] HDR_LAST   = 6'(HDR_W - 1);
   localparam logic [5:0] FRAME_LAST = 6'(HDR_W + DATA_W - 1);
   localparam logic [5:0] DATA_FIRST = 6'(HDR_W);

   logic cs_level, cs_rise, cs_fall;
   logic sclk_level, sclk_rise, sclk_fall;
   logic mosi_level, mosi_rise, mosi_fall;
   logic unused_edges;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
      .clk(clk), .d(_cs_i), .level(cs_level), .rise(cs_rise), .fall(cs_fall));
   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk(clk), .d(sclk_i), .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall));
   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
      .clk(clk), .d(mosi_i), .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall));

   assign unused_edges = ^{sclk_level, mosi_rise, mosi_fall};

   state_t            state_q, state_d;
   logic [5:0]        bitcnt_q, bitcnt_d;
   logic [HDR_W-1:0]  hdr_sh_q, hdr_sh_d, hdr_d;
   logic [DATA_W-1:0] data_sh_q, data_sh_d, data_d;
   logic [DATA_W-1:0] rsp_sh_q, rsp_sh_d;
   logic              hdr_v_d, data_v_d, abort_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= cs_level ? IDLE : DONE;
         bitcnt_q    <= '0;
         hdr_sh_q    <= '0;
         data_sh_q   <= '0;
         rsp_sh_q    <= '0;
         hdr_o       <= '0;
         data_o      <= '0;
         hdr_valid   <= 1'b0;
         data_valid  <= 1'b0;
         frame_abort <= 1'b0;
         miso_o      <= 1'b0;
         miso_oe     <= 1'b0;
      end else begin
         state_q     <= state_d;
         bitcnt_q    <= bitcnt_d;
         hdr_sh_q    <= hdr_sh_d;
         data_sh_q   <= data_sh_d;
         rsp_sh_q    <= rsp_sh_d;
         hdr_o       <= hdr_d;
         data_o      <= data_d;
         hdr_valid   <= hdr_v_d;
         data_valid  <= data_v_d;
         frame_abort <= abort_d;
         miso_o      <= (state_q == DATA) ? rsp_sh_q[DATA_W-1] : 1'b0;
         miso_oe     <= ~cs_level;
      end
   end

   always_comb begin
      state_d   = state_q;
      bitcnt_d  = bitcnt_q;
      hdr_sh_d  = hdr_sh_q;
      data_sh_d = data_sh_q;
      rsp_sh_d  = rsp_sh_q;
      hdr_d     = hdr_o;
      data_d    = data_o;
      hdr_v_d   = 1'b0;
      data_v_d  = 1'b0;
      abort_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d   = HDR;
               bitcnt_d  = '0;
               hdr_sh_d  = '0;
               data_sh_d = '0;
            end
         end
         HDR: begin
            if (sclk_rise) begin
               hdr_sh_d = {hdr_sh_q[HDR_W-2:0], mosi_level};
               bitcnt_d = bitcnt_q + 6'd1;
               if (bitcnt_q == HDR_LAST) begin
                  hdr_d    = hdr_sh_d;
                  hdr_v_d  = 1'b1;
                  rsp_sh_d = '0;
                  state_d  = DATA;
               end
            end
         end
         DATA: begin
            if (sclk_rise) begin
               data_sh_d = {data_sh_q[DATA_W-2:0], mosi_level};
               bitcnt_d  = bitcnt_q + 6'd1;
               if (bitcnt_q == FRAME_LAST) begin
                  data_d   = data_sh_d;
                  data_v_d = 1'b1;
                  if (MULTIFRAME) begin
                     state_d  = HDR;
                     bitcnt_d = '0;
                  end else begin
                     state_d = DONE;
                  end
               end
            end else if (sclk_fall) begin
               // No rise seen yet in DATA means this is the load fall.
               rsp_sh_d = (bitcnt_q == DATA_FIRST) ? rsp_i : {rsp_sh_q[DATA_W-2:0], 1'b0};
            end
         end
         DONE: begin
            if (cs_rise) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Chip select release is applied after any coincident sclk edge.
      if (cs_rise && (state_q == HDR || state_q == DATA)) begin
         state_d = IDLE;
         abort_d = !data_v_d &&
                   !(MULTIFRAME && state_q == HDR && bitcnt_q == '0 && !sclk_rise);
      end
   end

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_spi_word_slave.sv
// Self-checking bench for spi_word_slave: table vectors, random frames, reset corner.
module tb_spi_word_slave;
   import spi_word_slave_pkg::*;

`ifdef SPI_WORD_SLAVE_MULTIFRAME_EN
   localparam bit MULTI = 1'b1;
`else
   localparam bit MULTI = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, cs_n, sclk, mosi;
   logic        miso, miso_oe, hdr_valid, data_valid, frame_abort, busy;
   logic [15:0] hdr;
   logic [31:0] rsp, data;

   spi_word_slave dut (
      .clk(clk), .reset(reset), ._cs_i(cs_n), .sclk_i(sclk), .mosi_i(mosi),
      .miso_o(miso), .miso_oe(miso_oe), .hdr_o(hdr), .hdr_valid(hdr_valid),
      .rsp_i(rsp), .data_o(data), .data_valid(data_valid),
      .frame_abort(frame_abort), .busy(busy));

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   bit          tx_bits[$];
   bit          rx_bits[$];
   bit          exp_miso[$];
   logic [15:0] got_hdr[$], exp_hdr[$];
   logic [31:0] got_data[$], exp_data[$];
   int          got_abort, exp_abort;
   logic [15:0] exp_hdr_last;
   logic [31:0] exp_data_last;

   typedef struct {
      logic [47:0] w0;
      logic [47:0] w1;
      int          n;
      bit          cs_last;
      logic [31:0] rsp;
      int          nh, nd, na;
   } vec_t;
   vec_t tbl[6];

   always @(negedge clk) begin
      if (hdr_valid)   got_hdr.push_back(hdr);
      if (data_valid)  got_data.push_back(data);
      if (frame_abort) got_abort++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic load_words(input logic [47:0] w0, input logic [47:0] w1);
      tx_bits.delete();
      for (int i = 0; i < 48; i++) tx_bits.push_back(w0[47-i]);
      for (int i = 0; i < 48; i++) tx_bits.push_back(w1[47-i]);
      for (int i = 0; i < 16; i++) tx_bits.push_back(1'b1);
   endtask

   function automatic logic [47:0] get_bits(input int start, input int len);
      logic [47:0] w = '0;
      for (int j = 0; j < len; j++) w = {w[46:0], tx_bits[start+j]};
      return w;
   endfunction

   // Reference: whole frames decode, a trailing partial frame aborts,
   // and MISO carries the response word MSB-first during each data phase.
   task automatic build_expect(input int n);
      int frames, rem, j;
      exp_hdr.delete(); exp_data.delete(); exp_miso.delete();
      if (MULTI) begin
         frames = n / 48;
         rem    = n % 48;
      end else begin
         frames = (n >= 48) ? 1 : 0;
         rem    = (n >= 48) ? 0 : n;
      end
      for (int k = 0; k < frames; k++) begin
         exp_hdr.push_back(16'(get_bits(k*48, 16)));
         exp_data.push_back(32'(get_bits(k*48 + 16, 32)));
      end
      if (rem >= 16) exp_hdr.push_back(16'(get_bits(frames*48, 16)));
      exp_abort = (rem != 0) ? 1 : 0;
      for (int i = 0; i < n; i++) begin
         j = MULTI ? (i % 48) : i;
         exp_miso.push_back((j >= 16 && j < 48) ? rsp[47-j] : 1'b0);
      end
      if (exp_hdr.size() > 0)  exp_hdr_last  = exp_hdr[exp_hdr.size()-1];
      if (exp_data.size() > 0) exp_data_last = exp_data[exp_data.size()-1];
   endtask

   // clk/8 mode-0 master: mosi set at the fall, MISO sampled just before the rise.
   task automatic clock_bits(input int start, input int count, input bit cs_last);
      for (int i = start; i < start + count; i++) begin
         mosi = tx_bits[i];
         repeat (4) @(negedge clk);
         rx_bits.push_back(miso);
         sclk = 1'b1;
         if (cs_last && i == start + count - 1) cs_n = 1'b1;
         repeat (4) @(negedge clk);
         sclk = 1'b0;
      end
   endtask

   task automatic run_case(input int n, input bit cs_last, input int nh, input int nd, input int na);
      int errs;
      got_hdr.delete(); got_data.delete(); got_abort = 0; rx_bits.delete();
      build_expect(n);
      cs_n = 1'b0;
      repeat (8) @(negedge clk);
      check("miso_oe_active", miso_oe, 1'b1);
      clock_bits(0, n, cs_last);
      repeat (4) @(negedge clk);
      cs_n = 1'b1;
      repeat (12) @(negedge clk);
      if (nh >= 0) begin
         check("hdr_pulses_tbl",   got_hdr.size(),  nh);
         check("data_pulses_tbl",  got_data.size(), nd);
         check("abort_pulses_tbl", got_abort,       na);
      end
      check("hdr_pulses",   got_hdr.size(),  exp_hdr.size());
      check("data_pulses",  got_data.size(), exp_data.size());
      check("abort_pulses", got_abort,       exp_abort);
      for (int k = 0; k < got_hdr.size() && k < exp_hdr.size(); k++)
         check("hdr_value", got_hdr[k], exp_hdr[k]);
      for (int k = 0; k < got_data.size() && k < exp_data.size(); k++)
         check("data_value", got_data[k], exp_data[k]);
      errs = 0;
      for (int i = 0; i < exp_miso.size(); i++)
         if (rx_bits[i] !== exp_miso[i]) errs++;
      check("miso_bits_wrong", errs, 0);
      check("hdr_o_hold",  hdr,     exp_hdr_last);
      check("data_o_hold", data,    exp_data_last);
      check("busy_idle",   busy,    1'b0);
      check("miso_oe_off", miso_oe, 1'b0);
   endtask

   initial begin
      reset = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0; rsp = '0;
      got_abort = 0; exp_hdr_last = '0; exp_data_last = '0;

      tbl[0] = '{48'hA55A_DEADBEEF, 48'h0,              48, 1'b0, 32'h12345678, 1, 1, 0};
      tbl[1] = '{48'h1234_CAFEF00D, 48'h0,              20, 1'b0, 32'h0F0F0F0F, 1, 0, 1};
      tbl[2] = '{48'h5AA5_01234567, 48'h0,              48, 1'b0, 32'h89ABCDEF, 1, 1, 0};
`ifdef SPI_WORD_SLAVE_MULTIFRAME_EN
      tbl[3] = '{48'hC3C3_87654321, 48'hFFFF_FFFFFFFF,  50, 1'b0, 32'hA5A5A5A5, 1, 1, 1};
      tbl[4] = '{48'h0001_00000001, 48'h0002_00000002,  96, 1'b0, 32'h3C3C3C3C, 2, 2, 0};
`else
      tbl[3] = '{48'hC3C3_87654321, 48'hFFFF_FFFFFFFF,  50, 1'b0, 32'hA5A5A5A5, 1, 1, 0};
      tbl[4] = '{48'h0001_00000001, 48'h0002_00000002,  96, 1'b0, 32'h3C3C3C3C, 1, 1, 0};
`endif
      tbl[5] = '{48'h0F0F_F0F0A5A5, 48'h0,              48, 1'b1, 32'hFEDCBA98, 1, 1, 0};

      repeat (6) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_hdr_o",      hdr,         16'h0);
      check("rst_data_o",     data,        32'h0);
      check("rst_hdr_valid",  hdr_valid,   1'b0);
      check("rst_data_valid", data_valid,  1'b0);
      check("rst_abort",      frame_abort, 1'b0);
      check("rst_busy",       busy,        1'b0);
      check("rst_miso",       miso,        1'b0);
      check("rst_miso_oe",    miso_oe,     1'b0);

      for (int v = 0; v < 6; v++) begin
         load_words(tbl[v].w0, tbl[v].w1);
         rsp = tbl[v].rsp;
         run_case(tbl[v].n, tbl[v].cs_last, tbl[v].nh, tbl[v].nd, tbl[v].na);
      end

      // Reset at bit 30 with chip select held low: rest of the frame is dead.
      load_words(48'h1111_22223333, 48'h0);
      rsp = 32'h55AA55AA;
      got_hdr.delete(); got_data.delete(); got_abort = 0; rx_bits.delete();
      cs_n = 1'b0;
      repeat (8) @(negedge clk);
      clock_bits(0, 30, 1'b0);
      check("pre_rst_hdr_pulse", got_hdr.size(), 1);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      exp_hdr_last = '0; exp_data_last = '0;
      got_hdr.delete(); got_data.delete(); got_abort = 0;
      check("mid_rst_busy",   busy, 1'b1);
      check("mid_rst_hdr_o",  hdr,  16'h0);
      check("mid_rst_data_o", data, 32'h0);
      clock_bits(30, 18, 1'b0);
      repeat (4) @(negedge clk);
      cs_n = 1'b1;
      repeat (12) @(negedge clk);
      check("mid_rst_hdr_pulses",   got_hdr.size(),  0);
      check("mid_rst_data_pulses",  got_data.size(), 0);
      check("mid_rst_abort_pulses", got_abort,       0);
      check("mid_rst_busy_after",   busy,            1'b0);
      load_words(48'h9876_13579BDF, 48'h0);
      rsp = 32'h2468ACE0;
      run_case(48, 1'b0, 1, 1, 0);

      for (int r = 0; r < 20; r++) begin
         int  n;
         logic [47:0] w0, w1;
         w0  = {16'($urandom), 32'($urandom)};
         w1  = {16'($urandom), 32'($urandom)};
         rsp = 32'($urandom);
         case ($urandom_range(0, 3))
            0:       n = $urandom_range(1, 60);
            1:       n = MULTI ? 96 : 48;
            default: n = 48;
         endcase
         load_words(w0, w1);
         run_case(n, 1'($urandom_range(0, 1)), -1, -1, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
